bk_byte_serial_adder: RTL and testbench
=======================================

BK_BYTE_SERIAL_ADDER -- requirements
Module: bk_byte_serial_adder

Interface
REQ-001 SHALL have parameter NBYTES, default 2, number of 8-bit bytes per operand (NBYTES >= 1).
REQ-002 SHALL have one clock and a synchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand transaction offered.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  8*NBYTES  operand A.
REQ-008 b  input  8*NBYTES  operand B.
REQ-009 cin  input  1  carry-in of transaction.
REQ-010 out_valid  output  1  result held and valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  8*NBYTES  registered result.
REQ-013 cout  output  1  registered carry-out.
REQ-014 pn_p  output  8  propagate byte to the external 8-bit prefix carry network.
REQ-015 pn_g  output  8  generate byte to the prefix network.
REQ-016 pn_cin  output  1  carry-in to the prefix network.
REQ-017 pn_gx  input  8  group generates returned combinationally by the prefix network; pn_gx[i], i>=1, is the carry into bit i; pn_gx[0] is ignored.
REQ-018 pn_px  input  8  propagate pass-through returned by the prefix network.
REQ-019 pn_err  output  1  sticky flag, set on a pn_px/pn_p mismatch.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE: in_ready=1, out_valid=0; in_valid=1 captures a, b and cin into internal registers, clears byte index k to 0, sets carry register to cin, and transitions to RUN.
REQ-022 RUN, byte k: pn_p = a_byte[k] XOR b_byte[k], pn_g = a_byte[k] AND b_byte[k], pn_cin = carry register.
REQ-023 RUN, byte k at each edge: sum byte k <= pn_p XOR {pn_gx[7:1], pn_cin}; carry register <= pn_g[7] OR (pn_p[7] AND pn_gx[7]); k increments.
REQ-024 RUN SHALL exit to DONE at the edge that processes byte NBYTES-1; cout is loaded with that byte's carry-out at the same edge.
REQ-025 Latency: out_valid SHALL rise exactly NBYTES cycles after the accepting edge.
REQ-026 DONE: out_valid=1 and in_ready=0; sum and cout SHALL hold stable until out_valid AND out_ready, after which the block returns to IDLE and in_ready=1 on the next cycle.
REQ-027 in_ready=0 in RUN and DONE; in_valid is ignored there, so there is no overlap of transactions and in_ready SHALL not depend combinationally on in_valid or out_ready.
REQ-028 In IDLE and DONE, pn_p, pn_g and pn_cin SHALL be driven to 0.
REQ-029 In RUN, pn_p != pn_px SHALL set pn_err at that edge; pn_err remains 1 until reset; sum still uses the block's own pn_p.
REQ-030 Arithmetic: {cout, sum} SHALL equal a + b + cin modulo 2^(8*NBYTES+1).
REQ-031 Between transactions, sum and cout SHALL retain the last result; they change only during RUN.
REQ-032 With NBYTES=1, RUN SHALL last exactly one cycle.

Reset
REQ-033 rst=1 SHALL force state IDLE, k=0, carry register=0, sum=0, cout=0, out_valid=0, pn_err=0 and in_ready=1 after the edge.
REQ-034 rst SHALL take priority over any handshake in the same cycle, including mid-RUN and DONE, and SHALL abort the transaction without producing output.

Verification
REQ-035 NBYTES=2, a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, out_valid 2 cycles after accept.
REQ-036 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
REQ-038 rst pulsed while in RUN at k=1 -> all outputs 0 next cycle; the following transaction a=0x8000, b=0x8000 -> sum=0x0000, cout=1.
REQ-039 Prefix-model fault: pn_px bit 3 inverted for one RUN cycle -> pn_err=1 and stays 1 through later transactions until rst.
REQ-040 Random a/b/cin for 10k transactions with random out_ready against the REQ-030 model, using a correct 8-bit carry-network model on pn_*, SHALL report zero mismatches and pn_err=0.

Source files
------------

// File: rtl/bk_byte_serial_adder.sv
// rtl/bk_byte_serial_adder.sv - byte-serial adder driving an external 8-bit prefix carry network
module bk_byte_serial_adder #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic [7:0]            pn_p,
    output logic [7:0]            pn_g,
    output logic                  pn_cin,
    input  logic [7:0]            pn_gx,
    input  logic [7:0]            pn_px,
    output logic                  pn_err
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic [KW-1:0]  k_q;
    logic           carry_q;
    logic           cout_q;
    logic           err_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [7:0]     byte_sum_d;
    logic           carry_d;

    // bit 0 of the network's group generate carries no information: carry into bit 0 is pn_cin
    logic           unused_gx0;
    assign unused_gx0 = pn_gx[0];

    assign a_byte = a_q[8*k_q +: 8];
    assign b_byte = b_q[8*k_q +: 8];

    // propagate/generate of the current byte go out only while a byte is being processed
    always_comb begin
        pn_p   = 8'h00;
        pn_g   = 8'h00;
        pn_cin = 1'b0;
        if (state_q == S_RUN) begin
            pn_p   = a_byte ^ b_byte;
            pn_g   = a_byte & b_byte;
            pn_cin = carry_q;
        end
    end

    // byte sum uses our own propagate; the network only supplies the per-bit carries
    assign byte_sum_d = pn_p ^ {pn_gx[7:1], pn_cin};
    assign carry_d    = pn_g[7] | (pn_p[7] & pn_gx[7]);

    // control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[8*k_q +: 8] <= byte_sum_d;
                    carry_q           <= carry_d;
                    if (pn_px != pn_p) begin
                        err_q <= 1'b1;
                    end
                    if (k_q == K_LAST) begin
                        cout_q      <= carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign pn_err    = err_q;

endmodule

// File: tb/tb_bk_byte_serial_adder.sv
// tb/tb_bk_byte_serial_adder.sv - scoreboard bench for bk_byte_serial_adder
module tb_bk_byte_serial_adder;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic [7:0]    pn_p;
    logic [7:0]    pn_g;
    logic          pn_cin;
    logic [7:0]    pn_gx;
    logic [7:0]    pn_px;
    logic          pn_err;
    logic [7:0]    px_fault;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [63:0]   sb[$];

    always #5 clk = ~clk;

    bk_byte_serial_adder #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .pn_p      (pn_p),
        .pn_g      (pn_g),
        .pn_cin    (pn_cin),
        .pn_gx     (pn_gx),
        .pn_px     (pn_px),
        .pn_err    (pn_err)
    );

    // reference ripple carry network: gx[i] is the carry into bit i
    always_comb begin
        logic c;
        c = pn_cin;
        pn_gx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pn_gx[i] = c;
            c = pn_g[i] | (pn_p[i] & c);
        end
        pn_px = pn_p ^ px_fault;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // pop and compare whenever a result handshake is about to complete
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd0, 64'd1);
            end else begin
                check("result", {47'd0, cout, sum}, sb.pop_front());
            end
        end
    end

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input int stall, input bit inject);
        int          lat;
        int          wait_n;
        logic [W:0]  snap;
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        sb.push_back(64'({1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc}));
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        px_fault = inject ? 8'h08 : 8'h00;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            px_fault = 8'h00;
            lat++;
        end
        check("latency", 64'(lat), 64'(NB));
        snap = {cout, sum};
        for (int i = 0; i < stall; i++) begin
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'({cout, sum}), 64'(snap));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        px_fault = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'({cout, sum}), 64'd0);
        check("rst_err", 64'(pn_err), 64'd0);
        check("idle_pn", 64'({pn_p, pn_g, pn_cin}), 64'd0);

        run_txn(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        check("dir_00ff", 64'({cout, sum}), 64'h0100);
        run_txn(16'hFFFF, 16'h0000, 1'b1, 1, 1'b0);
        check("dir_ffff", 64'({cout, sum}), 64'h10000);
        run_txn(16'h1234, 16'h4321, 1'b0, 5, 1'b0);
        check("dir_1234", 64'({cout, sum}), 64'h05555);
        check("retain_sum", 64'({cout, sum}), 64'h05555);
        check("idle_pn_after", 64'({pn_p, pn_g, pn_cin}), 64'd0);

        // abort mid-run at k=1
        a = 16'hABCD; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", 64'({out_valid, cout, sum, pn_err}), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end
        run_txn(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        check("dir_8000", 64'({cout, sum}), 64'h10000);

        // prefix network fault makes pn_err sticky
        run_txn(16'h5A5A, 16'h0F0F, 1'b0, 0, 1'b1);
        check("err_set", 64'(pn_err), 64'd1);
        run_txn(16'h0001, 16'h0002, 1'b0, 0, 1'b0);
        check("err_sticky", 64'(pn_err), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("err_cleared", 64'(pn_err), 64'd0);

        for (int n = 0; n < 10000; n++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end
        check("rand_err", 64'(pn_err), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
